// File: rtl/multi_ch_nco_clkgen.sv
// Multi-channel NCO clock-enable generator: per-channel phase accumulators produce ce_out strobes and square waves.
// ce_out lags the wrapping add by one register; cfg_ready is high from the first edge after reset, so config never stalls.
module multi_ch_nco_clkgen #(
    parameter int NUM_CH      = 3,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16,
    parameter logic [NUM_CH*ACC_W-1:0] INIT_INC   = {NUM_CH{1'b1, {(ACC_W-1){1'b0}}}},
    parameter logic [NUM_CH*ACC_W-1:0] INIT_PHASE = '0
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              resync,
    output logic [NUM_CH-1:0] ce_out,
    output logic [NUM_CH-1:0] div_clk,
    output logic              locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

    typedef enum logic {SETTLE, LOCKED} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] inc   [NUM_CH];
    logic [ACC_W-1:0] phase [NUM_CH];
    logic [ACC_W-1:0] acc   [NUM_CH];
    logic [ACC_W:0]   sum   [NUM_CH];

    logic accept;
    logic wr;
    logic restart;
    logic run;

    assign accept  = cfg_valid & cfg_ready;
    // Out-of-range channel indices are consumed but touch nothing.
    assign wr      = accept & ({1'b0, cfg_ch} < 5'(NUM_CH));
    assign restart = wr | resync;
    // The restart edge itself freezes the accumulators so no strobe leaks out while unlocking.
    assign run     = (state == LOCKED) & ~restart;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum[i] = {1'b0, acc[i]} + {1'b0, inc[i]};
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_div
        assign div_clk[g] = acc[g][ACC_W-1];
    end

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state     <= SETTLE;
            cnt       <= '0;
            locked    <= 1'b0;
            cfg_ready <= 1'b0;
            ce_out    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                inc[i]   <= INIT_INC[i*ACC_W +: ACC_W];
                phase[i] <= INIT_PHASE[i*ACC_W +: ACC_W];
                acc[i]   <= INIT_PHASE[i*ACC_W +: ACC_W];
            end
        end else begin
            cfg_ready <= 1'b1;
            if (restart) begin
                state  <= SETTLE;
                cnt    <= '0;
                locked <= 1'b0;
            end else if (state == SETTLE) begin
                if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
                    state  <= LOCKED;
                    locked <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                ce_out[i] <= run & sum[i][ACC_W];
                if (wr && (cfg_ch == 4'(i))) begin
                    inc[i]   <= cfg_inc;
                    phase[i] <= cfg_phase;
                    acc[i]   <= cfg_phase;
                end else if (resync) begin
                    acc[i] <= phase[i];
                end else if (run) begin
                    acc[i] <= sum[i][ACC_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_ch_nco_clkgen.sv
// Bench for multi_ch_nco_clkgen: vector table of config scenarios, hand-written corner sequences, random traffic vs a reference model.
module tb_multi_ch_nco_clkgen;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int LC  = 16;

    logic            refclk = 1'b0;
    logic            rst = 1'b0;
    logic            cfg_valid = 1'b0;
    logic [3:0]      cfg_ch = '0;
    logic [AW-1:0]   cfg_inc = '0;
    logic [AW-1:0]   cfg_phase = '0;
    logic            resync = 1'b0;
    logic            cfg_ready;
    logic [NCH-1:0]  ce_out;
    logic [NCH-1:0]  div_clk;
    logic            locked;

    multi_ch_nco_clkgen #(.NUM_CH(NCH), .ACC_W(AW), .LOCK_CYCLES(LC)) dut (
        .refclk(refclk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_phase(cfg_phase), .resync(resync),
        .ce_out(ce_out), .div_clk(div_clk), .locked(locked)
    );

    always #5 refclk = ~refclk;

    int total = 0;
    int bad   = 0;

    // Reference model: channel registers plus "edges since the last restart event".
    logic [AW-1:0]  m_inc   [NCH];
    logic [AW-1:0]  m_phase [NCH];
    logic [AW-1:0]  m_acc   [NCH];
    logic [NCH-1:0] m_ce;
    bit             m_ready;
    int             m_age;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit wr, run;
        longint unsigned s;
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_inc[i] = 32'h8000_0000; m_phase[i] = '0; m_acc[i] = '0;
            end
            m_ce = '0; m_ready = 0; m_age = 0;
        end else begin
            wr  = cfg_valid && m_ready && (int'(cfg_ch) < NCH);
            run = (m_age >= LC) && !(wr || resync);
            for (int i = 0; i < NCH; i++) begin
                s = 64'(m_acc[i]) + 64'(m_inc[i]);
                m_ce[i] = run && (s >= 64'h1_0000_0000);
                if (wr && int'(cfg_ch) == i) begin
                    m_inc[i] = cfg_inc; m_phase[i] = cfg_phase; m_acc[i] = cfg_phase;
                end else if (resync) begin
                    m_acc[i] = m_phase[i];
                end else if (run) begin
                    m_acc[i] = s[AW-1:0];
                end
            end
            if (wr || resync) m_age = 0;
            else if (m_age < 100000) m_age++;
            m_ready = 1;
        end
    endtask

    task automatic step();
        logic [NCH-1:0] mdiv;
        @(posedge refclk);
        model_edge();
        #1;
        for (int i = 0; i < NCH; i++) mdiv[i] = m_acc[i][AW-1];
        check("locked", locked, (m_age >= LC));
        check("ce_out", ce_out, m_ce);
        check("div_clk", div_clk, mdiv);
        check("cfg_ready", cfg_ready, m_ready);
    endtask

    task automatic wait_lock(output int k);
        k = 0;
        while (!locked && k < 200) begin
            step();
            k++;
        end
    endtask

    typedef struct {
        logic [3:0]    ch;
        logic [AW-1:0] inc;
        logic [AW-1:0] phase;
        bit            rsy;
        int            n;
        int            exp_cnt;
        int            exp_first;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int k;
        int cnt [NCH];
        int first;
        logic [AW-1:0] acc0 [NCH];
        logic d0;

        tbl[0] = '{4'd2, 32'hA8F5_C28F, 32'h0000_0000, 1'b0, 1000, 659, 2};
        tbl[1] = '{4'd1, 32'h4000_0000, 32'h8000_0000, 1'b0, 100,  25,  2};
        tbl[2] = '{4'd0, 32'h0000_0000, 32'h0000_0000, 1'b0, 200,  0,   -1};
        tbl[3] = '{4'd0, 32'h8000_0000, 32'hC000_0000, 1'b1, 4,    2,   1};
        tbl[4] = '{4'd1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 50,   49,  2};
        tbl[5] = '{4'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 5,    1,   2};
        tbl[6] = '{4'd2, 32'hC000_0000, 32'h8000_0000, 1'b0, 8,    6,   1};

        // Reset and default lock-up.
        rst = 1'b0;
        repeat (3) step();
        check("rst_locked", locked, 1'b0);
        check("rst_ready", cfg_ready, 1'b0);
        check("rst_ce", ce_out, 3'b000);
        check("rst_div", div_clk, 3'b000);
        rst = 1'b1;
        wait_lock(k);
        check("init_lock_len", k, LC);
        for (int j = 1; j <= 6; j++) begin
            step();
            check("init_ce_pattern", ce_out, (j % 2 == 0) ? 3'b111 : 3'b000);
            check("init_div_pattern", div_clk, (j % 2 == 1) ? 3'b111 : 3'b000);
        end

        // Vector table: program, verify relock length, then count strobes over a locked window.
        for (int t = 0; t < 7; t++) begin
            cfg_valid = 1'b1; cfg_ch = tbl[t].ch; cfg_inc = tbl[t].inc;
            cfg_phase = tbl[t].phase; resync = tbl[t].rsy;
            step();
            cfg_valid = 1'b0; resync = 1'b0;
            check("unlock_after_cfg", locked, 1'b0);
            wait_lock(k);
            check("relock_len", k + 1, LC + 1);
            check("div_at_lock", div_clk[tbl[t].ch], tbl[t].phase[AW-1]);
            for (int i = 0; i < NCH; i++) begin
                acc0[i] = m_acc[i];
                cnt[i] = 0;
            end
            first = -1;
            d0 = div_clk[tbl[t].ch];
            for (int j = 1; j <= tbl[t].n; j++) begin
                step();
                for (int i = 0; i < NCH; i++) if (ce_out[i]) cnt[i]++;
                if (first < 0 && ce_out[tbl[t].ch]) first = j;
            end
            check("ce_count", cnt[tbl[t].ch], tbl[t].exp_cnt);
            check("first_ce", first, tbl[t].exp_first);
            if (tbl[t].inc == 0) check("div_stalled", div_clk[tbl[t].ch], d0);
            for (int i = 0; i < NCH; i++) begin
                if (i != int'(tbl[t].ch))
                    check("ce_count_other", cnt[i],
                          (64'(acc0[i]) + 64'(tbl[t].n) * 64'(m_inc[i])) >> AW);
            end

            // Invalid channel while locked: consumed, no relock.
            if (t == 1) begin
                cfg_valid = 1'b1; cfg_ch = 4'd7; cfg_inc = 32'h1234_5678; cfg_phase = 32'hFFFF_0000;
                step();
                cfg_valid = 1'b0;
                check("invalid_ch_keeps_lock", locked, 1'b1);
                repeat (8) begin
                    step();
                    check("invalid_ch_lock_hold", locked, 1'b1);
                end
            end
        end

        // Config every 10 cycles keeps the block unlocked.
        for (int r = 0; r < 10; r++) begin
            cfg_valid = 1'b1; cfg_ch = 4'(r % NCH); cfg_inc = $urandom; cfg_phase = $urandom;
            step();
            cfg_valid = 1'b0;
            repeat (9) begin
                step();
                check("no_lock_while_cfg", locked, 1'b0);
            end
        end
        // Reset mid-SETTLE, colliding with cfg and resync: INIT values win.
        cfg_valid = 1'b1; cfg_ch = 4'd0; cfg_inc = 32'h1; cfg_phase = 32'h8000_0000; resync = 1'b1;
        rst = 1'b0;
        step();
        cfg_valid = 1'b0; resync = 1'b0;
        check("midrst_div", div_clk, 3'b000);
        check("midrst_ready", cfg_ready, 1'b0);
        rst = 1'b1;
        wait_lock(k);
        check("midrst_relock_len", k, LC);
        for (int j = 1; j <= 4; j++) begin
            step();
            check("midrst_ce_pattern", ce_out, (j % 2 == 0) ? 3'b111 : 3'b000);
        end

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            cfg_valid = ($urandom_range(0, 24) == 0);
            cfg_ch    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(3, 15)) : 4'($urandom_range(0, NCH-1));
            case ($urandom_range(0, 4))
                0:       cfg_inc = 32'hFFFF_FFFF;
                1:       cfg_inc = 32'($urandom_range(0, 3));
                default: cfg_inc = $urandom;
            endcase
            cfg_phase = $urandom;
            resync    = ($urandom_range(0, 59) == 0);
            rst       = ($urandom_range(0, 799) != 0);
            step();
        end
        cfg_valid = 1'b0; resync = 1'b0; rst = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
